key_debounce_multi: RTL and testbench

Parametrised multi-channel key front end: synchronises `KEY_NUM` raw mechanical key inputs, debounces each independently and emits per-key single-cycle press, release and long-press events plus a stable level. It sits between the board key pins and any control logic that consumes key events. It is the multi-key, event-generating generation of the single-key debouncer.

---
 rtl/key_debounce_multi.sv | 165 ++++++++++++++++
 tb/tb_key_debounce_multi.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Multi-key front end: 2-flop sync, per-key debounce FSM, press/release/long events (+auto-repeat when KEY_REPEAT_EN is defined).
// Latency: key_level/key_press/key_release change DEB_CYC+2 edges after the first edge sampling a clean pin change.
// Backpressure: none; events are single-cycle pulses that the consumer must take when asserted.
module key_debounce_multi #(
  parameter int CLK_FRE        = 50_000_000,
  parameter int KEY_NUM        = 4,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 1000,
  parameter int REPEAT_MS      = 200,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic               clk_in,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int MS_CYC  = CLK_FRE / 1000;
  localparam int DEB_CYC = MS_CYC * DEBOUNCE_MS;
  localparam int DEB_W   = $clog2(DEB_CYC);
  localparam int MS_W    = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int LONG_W  = $clog2(LONG_MS + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MS - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_MS);

  // Pin level of a released key; the synchroniser resets to it so reset exit never looks like a press.
  localparam logic REL_LVL = (KEY_ACTIVE_LOW != 0);

`ifdef KEY_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_MS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);
`endif

  // Out-of-range configurations show up as this marker block in the elaborated hierarchy.
  if (KEY_NUM < 1 || DEB_CYC < 2 || LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_config
  end

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } key_state_t;

  logic [KEY_NUM-1:0] sync_q1;
  logic [KEY_NUM-1:0] sync_q2;
  logic [KEY_NUM-1:0] key_norm;

  // Two-flop synchroniser followed by a registered normalisation to pressed = 1.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q1  <= {KEY_NUM{REL_LVL}};
      sync_q2  <= {KEY_NUM{REL_LVL}};
      key_norm <= '0;
    end else begin
      sync_q1  <= key;
      sync_q2  <= sync_q1;
      key_norm <= sync_q2 ^ {KEY_NUM{REL_LVL}};
    end
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_state_t        state;
    logic [DEB_W-1:0]  deb_cnt;
    logic [MS_W-1:0]   ms_pre;
    logic [LONG_W-1:0] ms_cnt;
    logic              press_q;
    logic              release_q;
    logic              long_q;
    logic              lvl;
    logic              in_diff;
    logic              deb_done;
    logic              ms_wrap;
`ifdef KEY_REPEAT_EN
    logic [REP_W-1:0]  rep_cnt;
`endif

    assign lvl      = (state == HELD);
    assign in_diff  = key_norm[i] ^ lvl;
    assign deb_done = in_diff && (deb_cnt == DEB_LAST);
    assign ms_wrap  = (ms_pre == MS_LAST);

    // Debounce FSM with hold timing; a level change always wins over a same-cycle long/repeat tick.
    always_ff @(posedge clk_in or posedge sys_rst) begin
      if (sys_rst) begin
        state     <= IDLE;
        deb_cnt   <= '0;
        ms_pre    <= '0;
        ms_cnt    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
        rep_cnt   <= '0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;

        // Any cycle agreeing with the stable level restarts the window.
        if (!in_diff) begin
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end

        case (state)
          IDLE: begin
            if (deb_done) begin
              state   <= HELD;
              deb_cnt <= '0;
              press_q <= 1'b1;
              ms_pre  <= '0;
              ms_cnt  <= '0;
`ifdef KEY_REPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end
          HELD: begin
            if (deb_done) begin
              state     <= IDLE;
              deb_cnt   <= '0;
              release_q <= 1'b1;
              ms_pre    <= '0;
              ms_cnt    <= '0;
`ifdef KEY_REPEAT_EN
              rep_cnt   <= '0;
`endif
            end else begin
              ms_pre <= ms_wrap ? '0 : ms_pre + 1'b1;
              if (ms_wrap) begin
                if (ms_cnt == LONG_LAST) begin
                  ms_cnt <= LONG_SAT;
                  long_q <= 1'b1;
                end else if (ms_cnt != LONG_SAT) begin
                  ms_cnt <= ms_cnt + 1'b1;
`ifdef KEY_REPEAT_EN
                end else if (rep_cnt == REP_LAST) begin
                  rep_cnt <= '0;
                  press_q <= 1'b1;
                end else begin
                  rep_cnt <= rep_cnt + 1'b1;
`endif
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign key_level[i]   = lvl;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: scoreboard of expected (cycle, kind, channel) events plus level checks.
// Latency model: event at first-sample edge + DEB_CYC+2; long at press + LONG_MS*MS_CYC; repeat every REPEAT_MS*MS_CYC.
// Backpressure: none; every output pulse must match the head of the expected-event queue.
module tb_key_debounce_multi;

  localparam int KN      = 4;
  localparam int MS_CYC  = 100;
  localparam int DEB_CYC = 200;
  localparam int LAT     = DEB_CYC + 2;
  localparam int LONG_C  = 10 * MS_CYC;
  localparam int REP_C   = 5 * MS_CYC;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_LONG    = 2;

  logic          clk_in = 1'b0;
  logic          sys_rst = 1'b1;
  logic [KN-1:0] key = '1;
  logic [KN-1:0] key_level;
  logic [KN-1:0] key_press;
  logic [KN-1:0] key_release;
  logic [KN-1:0] key_long;

  key_debounce_multi #(
    .CLK_FRE       (100_000),
    .KEY_NUM       (KN),
    .DEBOUNCE_MS   (2),
    .LONG_MS       (10),
    .REPEAT_MS     (5),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk_in     (clk_in),
    .sys_rst    (sys_rst),
    .key        (key),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk_in = ~clk_in;

  // Count rising edges; an event seen at a negedge is tagged with the edge that produced it.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected events encoded as cycle*16 + kind*4 + channel, in output order.
  logic [63:0] sb_q[$];

  task automatic push_ev(input int at, input int kind, input int ch);
    sb_q.push_back(64'(at) * 64'd16 + 64'(kind * 4 + ch));
  endtask

  // Monitor: every observed pulse pops the head of the scoreboard.
  always @(negedge clk_in) begin
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < KN; c++) begin
        logic        bitv;
        logic [63:0] obs;
        logic [63:0] expv;
        bitv = (k == EV_PRESS) ? key_press[c] : (k == EV_RELEASE) ? key_release[c] : key_long[c];
        if (bitv !== 1'b0) begin
          obs = 64'(cyc) * 64'd16 + 64'(k * 4 + c);
          if (sb_q.size() == 0) begin
            check_val("unexpected_event", obs, '1);
          end else begin
            expv = sb_q.pop_front();
            check_val("event", obs, expv);
          end
        end
      end
    end
  end

  initial begin
    int d;
    int r;

    // Reset state
    repeat (3) @(negedge clk_in);
    check_val("rst_level", 64'(key_level), 64'd0);
    check_val("rst_press", 64'(key_press), 64'd0);
    check_val("rst_release", 64'(key_release), 64'd0);
    check_val("rst_long", 64'(key_long), 64'd0);
    sys_rst = 1'b0;
    repeat (10) @(negedge clk_in);
    check_val("rst_exit_level", 64'(key_level), 64'd0);

    // Clean press on key 0, released before the long-press time
    @(negedge clk_in);
    d = cyc;
    key[0] = 1'b0;
    push_ev(d + 1 + LAT, EV_PRESS, 0);
    repeat (300) @(negedge clk_in);
    check_val("t1_level_held", 64'(key_level), 64'b0001);
    repeat (200) @(negedge clk_in);
    key[0] = 1'b1;
    push_ev(cyc + 1 + LAT, EV_RELEASE, 0);
    repeat (LAT + 50) @(negedge clk_in);
    check_val("t1_level_rel", 64'(key_level), 64'b0000);

    // Bounce on key 1: toggle every 50 cycles for 1000 cycles, then hold pressed
    @(negedge clk_in);
    for (int k = 0; k < 20; k++) begin
      key[1] = (k % 2 == 1);
      repeat (50) @(negedge clk_in);
    end
    check_val("t2_level_bounce", 64'(key_level), 64'b0000);
    key[1] = 1'b0;
    push_ev(cyc + 1 + LAT, EV_PRESS, 1);
    repeat (300) @(negedge clk_in);
    check_val("t2_level_held", 64'(key_level), 64'b0010);
    key[1] = 1'b1;
    push_ev(cyc + 1 + LAT, EV_RELEASE, 1);
    repeat (LAT + 50) @(negedge clk_in);

    // Long press on key 2
    @(negedge clk_in);
    d = cyc;
    key[2] = 1'b0;
    push_ev(d + 1 + LAT, EV_PRESS, 2);
    push_ev(d + 1 + LAT + LONG_C, EV_LONG, 2);
    repeat (1200) @(negedge clk_in);
    check_val("t3_level_held", 64'(key_level), 64'b0100);
    repeat (300) @(negedge clk_in);
    key[2] = 1'b1;
    push_ev(cyc + 1 + LAT, EV_RELEASE, 2);
    repeat (LAT + 50) @(negedge clk_in);
    check_val("t3_level_rel", 64'(key_level), 64'b0000);

    // Hold key 3 for 2500 cycles: long press, plus repeats when compiled in
    @(negedge clk_in);
    d = cyc;
    key[3] = 1'b0;
    push_ev(d + 1 + LAT, EV_PRESS, 3);
    push_ev(d + 1 + LAT + LONG_C, EV_LONG, 3);
`ifdef KEY_REPEAT_EN
    push_ev(d + 1 + LAT + LONG_C + REP_C, EV_PRESS, 3);
    push_ev(d + 1 + LAT + LONG_C + 2 * REP_C, EV_PRESS, 3);
`endif
    repeat (2500) @(negedge clk_in);
    key[3] = 1'b1;
    push_ev(cyc + 1 + LAT, EV_RELEASE, 3);
    repeat (LAT + 50) @(negedge clk_in);

    // All keys pressed together, then reset while held
    @(negedge clk_in);
    d = cyc;
    key = '0;
    for (int c = 0; c < KN; c++) push_ev(d + 1 + LAT, EV_PRESS, c);
    repeat (LAT + 1 + 100) @(negedge clk_in);
    check_val("t5_level_all", 64'(key_level), 64'b1111);
    sys_rst = 1'b1;
    #1;
    check_val("t5_rst_level", 64'(key_level), 64'd0);
    check_val("t5_rst_press", 64'(key_press), 64'd0);
    check_val("t5_rst_release", 64'(key_release), 64'd0);
    check_val("t5_rst_long", 64'(key_long), 64'd0);
    repeat (5) @(negedge clk_in);
    sys_rst = 1'b0;
    r = cyc;
    // Keys still held: only a normally debounced press may follow reset exit.
    for (int c = 0; c < KN; c++) push_ev(r + 1 + LAT, EV_PRESS, c);
    repeat (150) @(negedge clk_in);
    check_val("t5_post_rst_level", 64'(key_level), 64'd0);
    repeat (100) @(negedge clk_in);
    check_val("t5_repress_level", 64'(key_level), 64'b1111);
    key = '1;
    for (int c = 0; c < KN; c++) push_ev(cyc + 1 + LAT, EV_RELEASE, c);
    repeat (LAT + 50) @(negedge clk_in);
    check_val("t5_final_level", 64'(key_level), 64'd0);

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
